// File: rtl/rob_dispatch_alloc_if.sv
// Decode-to-allocator handshake plus the ROB dispatch/commit port.
// The allocator connects through the slave modport.
interface rob_dispatch_alloc_if #(
    parameter int ROB_SEL  = 6,
    parameter int INSN_LEN = 32,
    parameter int REG_SEL  = 5
);
    logic                dec_valid_i;
    logic                dec_ready_o;
    logic [INSN_LEN-1:0] dec_pc_i;
    logic                dec_dstvalid_i;
    logic [REG_SEL-1:0]  dec_dst_i;
    logic                stall_i;
    logic [1:0]          comnum_i;
    logic                dp1_o;
    logic [ROB_SEL-1:0]  dp1_addr_o;
    logic [INSN_LEN-1:0] pc_dp1_o;
    logic                dstvalid_dp1_o;
    logic [REG_SEL-1:0]  dst_dp1_o;
    logic [ROB_SEL:0]    rob_count_o;
    logic                rob_full_o;
    logic                rob_empty_o;

    modport master (
        output dec_valid_i, dec_pc_i, dec_dstvalid_i, dec_dst_i, stall_i, comnum_i,
        input  dec_ready_o, dp1_o, dp1_addr_o, pc_dp1_o, dstvalid_dp1_o, dst_dp1_o,
        input  rob_count_o, rob_full_o, rob_empty_o
    );

    modport slave (
        input  dec_valid_i, dec_pc_i, dec_dstvalid_i, dec_dst_i, stall_i, comnum_i,
        output dec_ready_o, dp1_o, dp1_addr_o, pc_dp1_o, dstvalid_dp1_o, dst_dp1_o,
        output rob_count_o, rob_full_o, rob_empty_o
    );
endinterface

// File: rtl/rob_dispatch_alloc.sv
// Dispatch-side ROB allocator: hands out tail entries to decoded instructions,
// registers the dispatch port and tracks occupancy against ROB commits.
module rob_dispatch_alloc #(
    parameter int ROB_NUM  = 64,
    parameter int ROB_SEL  = 6,
    parameter int INSN_LEN = 32,
    parameter int REG_SEL  = 5
) (
    input logic                 clk_i,
    input logic                 reset_ni,
    rob_dispatch_alloc_if.slave bus
);
    localparam logic [ROB_SEL:0] FULL_COUNT = (ROB_SEL+1)'(ROB_NUM);

    logic [ROB_SEL-1:0]  tail;
    logic [ROB_SEL-1:0]  head;
    logic [ROB_SEL:0]    count;
    logic                ready;
    logic                accept;
    logic                commit;

    logic                dp1;
    logic [ROB_SEL-1:0]  dp1_addr;
    logic [INSN_LEN-1:0] pc_dp1;
    logic                dstvalid_dp1;
    logic [REG_SEL-1:0]  dst_dp1;

    // Ready depends only on registered count and stall; commits free slots
    // for the next cycle, never the current one.
    always_comb begin
        ready  = reset_ni && !bus.stall_i && (count != FULL_COUNT);
        accept = bus.dec_valid_i && ready;
        commit = (bus.comnum_i != 2'd0) && (count != '0);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            tail  <= '0;
            head  <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                tail <= tail + ROB_SEL'(1);
            end
            if (commit) begin
                head <= head + ROB_SEL'(1);
            end
            count <= count + {{ROB_SEL{1'b0}}, accept} - {{ROB_SEL{1'b0}}, commit};
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dp1          <= 1'b0;
            dp1_addr     <= '0;
            pc_dp1       <= '0;
            dstvalid_dp1 <= 1'b0;
            dst_dp1      <= '0;
        end else begin
            dp1 <= accept;
            if (accept) begin
                dp1_addr     <= tail;
                pc_dp1       <= bus.dec_pc_i;
                dstvalid_dp1 <= bus.dec_dstvalid_i;
                dst_dp1      <= bus.dec_dst_i;
            end
        end
    end

    always_comb begin
        bus.dec_ready_o    = ready;
        bus.dp1_o          = dp1;
        bus.dp1_addr_o     = dp1_addr;
        bus.pc_dp1_o       = pc_dp1;
        bus.dstvalid_dp1_o = dstvalid_dp1;
        bus.dst_dp1_o      = dst_dp1;
        bus.rob_count_o    = count;
        bus.rob_full_o     = (count == FULL_COUNT);
        bus.rob_empty_o    = (count == '0);
    end
endmodule

// File: tb/tb_rob_dispatch_alloc.sv
// Self-checking bench for rob_dispatch_alloc: vector table, directed corner
// sequences and randomized traffic against an occupancy/tail reference model.
module tb_rob_dispatch_alloc;
    localparam int ROBN = 64;

    logic clk;
    logic reset_ni;
    int   checks;
    int   failures;

    // reference model state
    int          m_count;
    int          m_tail;
    logic        e_dp1;
    logic [5:0]  e_addr;
    logic [31:0] e_pc;
    logic        e_dv;
    logic [4:0]  e_dst;

    rob_dispatch_alloc_if #(.ROB_SEL(6), .INSN_LEN(32), .REG_SEL(5)) bus ();

    rob_dispatch_alloc #(
        .ROB_NUM(64), .ROB_SEL(6), .INSN_LEN(32), .REG_SEL(5)
    ) dut (
        .clk_i   (clk),
        .reset_ni(reset_ni),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    task automatic check_outputs();
        chk("dp1", {63'd0, bus.dp1_o}, {63'd0, e_dp1});
        chk("dp1_addr", {58'd0, bus.dp1_addr_o}, {58'd0, e_addr});
        chk("pc_dp1", {32'd0, bus.pc_dp1_o}, {32'd0, e_pc});
        chk("dstvalid_dp1", {63'd0, bus.dstvalid_dp1_o}, {63'd0, e_dv});
        chk("dst_dp1", {59'd0, bus.dst_dp1_o}, {59'd0, e_dst});
        chk("rob_count", {57'd0, bus.rob_count_o}, 64'(m_count));
        chk("rob_full", {63'd0, bus.rob_full_o}, {63'd0, m_count == ROBN});
        chk("rob_empty", {63'd0, bus.rob_empty_o}, {63'd0, m_count == 0});
    endtask

    task automatic model_reset();
        m_count = 0;
        m_tail  = 0;
        e_dp1   = 1'b0;
        e_addr  = '0;
        e_pc    = '0;
        e_dv    = 1'b0;
        e_dst   = '0;
    endtask

    task automatic drive_idle();
        bus.dec_valid_i    = 1'b0;
        bus.dec_pc_i       = '0;
        bus.dec_dstvalid_i = 1'b0;
        bus.dec_dst_i      = '0;
        bus.stall_i        = 1'b0;
        bus.comnum_i       = 2'd0;
    endtask

    // One clock of traffic: drive at negedge, check ready mid-cycle, check
    // registered outputs just after the rising edge.
    task automatic step(input logic v, input logic [31:0] pc, input logic dv,
                        input logic [4:0] dst, input logic st, input logic [1:0] cn,
                        output logic rdy_seen);
        logic m_ready;
        logic acc;
        int   rel;
        @(negedge clk);
        bus.dec_valid_i    = v;
        bus.dec_pc_i       = pc;
        bus.dec_dstvalid_i = dv;
        bus.dec_dst_i      = dst;
        bus.stall_i        = st;
        bus.comnum_i       = cn;
        #1;
        m_ready  = !st && (m_count < ROBN);
        rdy_seen = bus.dec_ready_o;
        chk("dec_ready", {63'd0, bus.dec_ready_o}, {63'd0, m_ready});
        acc = v && m_ready;
        rel = (cn != 2'd0 && m_count > 0) ? 1 : 0;
        @(posedge clk);
        #1;
        if (acc) begin
            e_dp1  = 1'b1;
            e_addr = 6'(m_tail);
            e_pc   = pc;
            e_dv   = dv;
            e_dst  = dst;
            m_tail = (m_tail + 1) % ROBN;
        end else begin
            e_dp1 = 1'b0;
        end
        m_count = m_count + (acc ? 1 : 0) - rel;
        check_outputs();
    endtask

    task automatic do_reset();
        drive_idle();
        bus.dec_valid_i = 1'b1;
        reset_ni = 1'b0;
        #1;
        model_reset();
        chk("reset_ready", {63'd0, bus.dec_ready_o}, 64'd0);
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive_idle();
        reset_ni = 1'b1;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        dv;
        logic [4:0]  dst;
        logic        st;
        logic [1:0]  cn;
        logic        exp_ready;
        logic        exp_dp1;
        logic [5:0]  exp_addr;
        int          exp_count;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic r;
        checks   = 0;
        failures = 0;
        reset_ni = 1'b1;
        drive_idle();
        model_reset();

        //            v  pc          dv dst st cn  rdy dp1 addr cnt
        tbl[0] = '{1'b1, 32'h1000, 1'b1, 5'd5, 1'b0, 2'd0, 1'b1, 1'b1, 6'd0, 1};
        tbl[1] = '{1'b0, 32'h0,    1'b0, 5'd0, 1'b0, 2'd0, 1'b1, 1'b0, 6'd0, 1};
        tbl[2] = '{1'b1, 32'h2000, 1'b0, 5'd7, 1'b1, 2'd0, 1'b0, 1'b0, 6'd0, 1};
        tbl[3] = '{1'b1, 32'h2000, 1'b0, 5'd7, 1'b0, 2'd0, 1'b1, 1'b1, 6'd1, 2};
        tbl[4] = '{1'b1, 32'h3000, 1'b1, 5'd9, 1'b0, 2'd1, 1'b1, 1'b1, 6'd2, 2};
        tbl[5] = '{1'b0, 32'h0,    1'b0, 5'd0, 1'b0, 2'd1, 1'b1, 1'b0, 6'd2, 1};
        tbl[6] = '{1'b0, 32'h0,    1'b0, 5'd0, 1'b0, 2'd1, 1'b1, 1'b0, 6'd2, 0};
        tbl[7] = '{1'b0, 32'h0,    1'b0, 5'd0, 1'b0, 2'd1, 1'b1, 1'b0, 6'd2, 0};
        tbl[8] = '{1'b1, 32'h4000, 1'b1, 5'd3, 1'b0, 2'd3, 1'b1, 1'b1, 6'd3, 1};
        tbl[9] = '{1'b0, 32'h0,    1'b0, 5'd0, 1'b0, 2'd2, 1'b1, 1'b0, 6'd3, 0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].pc, tbl[i].dv, tbl[i].dst, tbl[i].st, tbl[i].cn, r);
            chk($sformatf("tbl%0d_ready", i), {63'd0, r}, {63'd0, tbl[i].exp_ready});
            chk($sformatf("tbl%0d_dp1", i), {63'd0, bus.dp1_o}, {63'd0, tbl[i].exp_dp1});
            chk($sformatf("tbl%0d_addr", i), {58'd0, bus.dp1_addr_o}, {58'd0, tbl[i].exp_addr});
            chk($sformatf("tbl%0d_count", i), {57'd0, bus.rob_count_o}, 64'(tbl[i].exp_count));
            if (i == 0) begin
                chk("first_pc", {32'd0, bus.pc_dp1_o}, 64'h1000);
                chk("first_dst", {59'd0, bus.dst_dp1_o}, 64'd5);
            end
        end

        // fill all 64 entries back to back
        do_reset();
        for (int i = 0; i < ROBN; i++) begin
            step(1'b1, 32'h100 + 32'(i) * 4, i[0], 5'(i), 1'b0, 2'd0, r);
            chk("fill_addr", {58'd0, bus.dp1_addr_o}, 64'(i));
        end
        chk("fill_full", {63'd0, bus.rob_full_o}, 64'd1);
        step(1'b1, 32'hDEAD, 1'b1, 5'd1, 1'b0, 2'd0, r);
        chk("full_no_ready", {63'd0, r}, 64'd0);
        chk("full_no_dp1", {63'd0, bus.dp1_o}, 64'd0);
        // commit while full: no same-cycle bypass
        step(1'b1, 32'hDEAD, 1'b1, 5'd1, 1'b0, 2'd1, r);
        chk("full_commit_ready", {63'd0, r}, 64'd0);
        chk("full_commit_count", {57'd0, bus.rob_count_o}, 64'd63);
        step(1'b1, 32'hDEAD, 1'b1, 5'd1, 1'b0, 2'd0, r);
        chk("wrap_ready", {63'd0, r}, 64'd1);
        chk("wrap_addr", {58'd0, bus.dp1_addr_o}, 64'd0);
        chk("wrap_count", {57'd0, bus.rob_count_o}, 64'd64);

        // drain a few, then steady accept + commit
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd1, r);
        for (int i = 0; i < 200; i++) begin
            step(1'b1, $urandom, 1'($urandom), 5'($urandom), 1'b0, 2'd1, r);
        end
        chk("steady_count", {57'd0, bus.rob_count_o}, 64'd60);

        // stall blocks accept, release accepts immediately
        step(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 2'd1, r);
        step(1'b1, 32'h5555, 1'b1, 5'd11, 1'b1, 2'd0, r);
        chk("stall_no_dp1", {63'd0, bus.dp1_o}, 64'd0);
        chk("stall_count", {57'd0, bus.rob_count_o}, 64'd59);
        step(1'b1, 32'h5555, 1'b1, 5'd11, 1'b0, 2'd0, r);
        chk("unstall_dp1", {63'd0, bus.dp1_o}, 64'd1);
        chk("unstall_pc", {32'd0, bus.pc_dp1_o}, 64'h5555);

        // asynchronous reset with a dispatch pulse outstanding
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 32'h9000 + 32'(i), 1'b1, 5'd2, 1'b0, 2'd0, r);
        chk("pre_async_dp1", {63'd0, bus.dp1_o}, 64'd1);
        chk("pre_async_count", {57'd0, bus.rob_count_o}, 64'd10);
        #2;
        drive_idle();
        reset_ni = 1'b0;
        #1;
        model_reset();
        chk("async_dp1", {63'd0, bus.dp1_o}, 64'd0);
        chk("async_ready", {63'd0, bus.dec_ready_o}, 64'd0);
        check_outputs();
        @(negedge clk);
        reset_ni = 1'b1;
        step(1'b1, 32'hABC0, 1'b0, 5'd4, 1'b0, 2'd0, r);
        chk("post_async_addr", {58'd0, bus.dp1_addr_o}, 64'd0);
        chk("post_async_count", {57'd0, bus.rob_count_o}, 64'd1);

        // randomized traffic: fill-biased phase then drain-biased phase
        for (int i = 0; i < 3000; i++) begin
            int unsigned c;
            logic [1:0] cn;
            c = $urandom_range(0, 9);
            if (i < 1500) cn = (c < 3) ? 2'd1 : ((c == 3) ? 2'($urandom_range(2, 3)) : 2'd0);
            else          cn = (c < 7) ? 2'd1 : ((c == 7) ? 2'($urandom_range(2, 3)) : 2'd0);
            step(($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 5'($urandom),
                 ($urandom_range(0, 5) == 0), cn, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rob_dispatch_alloc.md
Name: rob_dispatch_alloc

Overview:
- Dispatch-side allocator for the single-issue reorder buffer.
- Accepts one decoded instruction per cycle from decode via a valid/ready handshake and assigns it the next ROB entry (tail pointer).
- Drives the ROB dispatch port (dp1, dp1_addr, pc, dstvalid, dst) through a register stage.
- Tracks ROB occupancy and releases entries as the ROB reports commits (comnum), so it never allocates an entry that is still live.

Parameters:
- ROB_NUM, 64, number of ROB entries (power of two)
- ROB_SEL, 6, log2(ROB_NUM), width of ROB entry address
- INSN_LEN, 32, width of instruction PC
- REG_SEL, 5, width of logical register index

Ports:
- clk_i  in  1  clock, all state on rising edge
- reset_ni  in  1  asynchronous active-low reset
- dec_valid_i  in  1  decode presents an instruction
- dec_ready_o  out  1  allocator can accept this cycle
- dec_pc_i  in  INSN_LEN  instruction PC
- dec_dstvalid_i  in  1  instruction writes a destination register
- dec_dst_i  in  REG_SEL  logical destination register
- stall_i  in  1  downstream (reservation station) cannot take a dispatch this cycle
- comnum_i  in  2  number of ROB entries committed this cycle (legal values 0 or 1)
- dp1_o  out  1  dispatch strobe to ROB
- dp1_addr_o  out  ROB_SEL  allocated ROB entry
- pc_dp1_o  out  INSN_LEN  PC of dispatched instruction
- dstvalid_dp1_o  out  1  destination-valid of dispatched instruction
- dst_dp1_o  out  REG_SEL  destination of dispatched instruction
- rob_count_o  out  ROB_SEL+1  entries currently allocated (0..ROB_NUM)
- rob_full_o  out  1  rob_count_o == ROB_NUM
- rob_empty_o  out  1  rob_count_o == 0

Behaviour:
- Reset (reset_ni low, asynchronous):
  - tail pointer = 0, head pointer = 0, count = 0.
  - dp1_o = 0; dp1_addr_o, pc_dp1_o, dstvalid_dp1_o, dst_dp1_o = 0.
  - rob_empty_o = 1, rob_full_o = 0, dec_ready_o = 0 while in reset.
  - Reset release is consumed synchronously; first accept is possible on the first edge after deassertion.
- Handshake:
  - dec_ready_o = !stall_i && (count < ROB_NUM); combinational from registered count and stall_i only, never from dec_valid_i.
  - accept = dec_valid_i && dec_ready_o.
  - Decode holds its fields stable while valid && !ready.
- Dispatch latency: one cycle.
  - On an accept edge: dp1_o <= 1, dp1_addr_o <= tail, pc_dp1_o/dstvalid_dp1_o/dst_dp1_o <= decode fields, tail <= (tail+1) mod ROB_NUM.
  - Without an accept: dp1_o <= 0; other dp outputs hold their last value (don't-care while dp1_o = 0).
  - Back-to-back accepts produce consecutive dp1 pulses with consecutive addresses.
- Occupancy: count <= count + accept - comnum_i (comnum_i treated as 0/1); head <= (head + comnum_i) mod ROB_NUM. head is internal and tracks the ROB commit pointer.
- Simultaneous accept and commit: count unchanged, tail and head both advance.
- Full: count == ROB_NUM → ready = 0. A commit in the same cycle frees a slot for the next cycle only; there is no same-cycle bypass.
- Entry ROB_NUM-1 may be accepted (count goes ROB_NUM-1 → ROB_NUM). Tail wraps 63→0 with no gap.
- Error guards (assertions in the bench; RTL saturates):
  - comnum_i with count == 0 leaves count at 0.
  - comnum_i ≥ 2 is treated as 1.
- stall_i affects only ready. An already-registered dp1_o pulse still issues (ROB dispatch has no backpressure).
- Reset asserted mid-operation: all state clears immediately, including a pending dp1_o pulse.

Test Plan:
- Reset then a single accept (pc=0x1000, dst=5, dstvalid=1) → next cycle dp1_o=1, dp1_addr_o=0, pc_dp1_o=0x1000, dst_dp1_o=5, rob_count_o=1; following cycle dp1_o=0.
- 64 back-to-back accepts, no commits → addresses 0..63 in order, rob_full_o=1 after the 64th, dec_ready_o=0, 65th valid held without dp1.
- Full with comnum_i=1 and dec_valid_i held → ready is still 0 that cycle and rises next cycle; the accepted instruction gets addr 0 (wrap), count returns to 64.
- Steady state accept + comnum_i=1 every cycle for 200 cycles → count constant, dp1_addr_o wraps 63→0 correctly.
- stall_i=1 with dec_valid_i=1 → no dp1 pulse, count unchanged; release stall → accept on that cycle, dp1 next cycle.
- Assert reset_ni low asynchronously while dp1_o=1 and count=10 → outputs clear before the next clock edge; after release the first dispatch uses addr 0, count starts from 0.
